hash_table_top: RTL and testbench

HASH_TABLE_TOP -- requirements
Module: hash_table_top

---
 rtl/hash_table_top_if.sv | 69 ++++++
 rtl/hash_table_top.sv | 306 ++++++++++++++++++++++++++++++
 tb/tb_hash_table_top.sv | 433 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/hash_table_top_if.sv
// Shared opcode/result types and the command/result handshake
// interfaces for the chained hash table.
package hash_table_pkg;
  typedef enum logic [1:0] {
    OP_SEARCH = 2'd0,
    OP_INSERT = 2'd1,
    OP_DELETE = 2'd2
  } ht_op_e;

  typedef enum logic [2:0] {
    SEARCH_FOUND                     = 3'd0,
    SEARCH_NOT_SUCCESS_NO_ENTRY      = 3'd1,
    INSERT_SUCCESS                   = 3'd2,
    INSERT_SUCCESS_SAME_KEY          = 3'd3,
    INSERT_NOT_SUCCESS_TABLE_IS_FULL = 3'd4,
    DELETE_SUCCESS                   = 3'd5,
    DELETE_NOT_SUCCESS_NO_ENTRY      = 3'd6
  } ht_rescode_e;
endpackage

interface ht_cmd_if #(
  parameter int KEY_WIDTH   = 32,
  parameter int VALUE_WIDTH = 16
);
  import hash_table_pkg::*;

  logic                   valid;
  logic                   ready;
  ht_op_e                 op;
  logic [KEY_WIDTH-1:0]   key;
  logic [VALUE_WIDTH-1:0] value;

  modport master (
    output valid, op, key, value,
    input  ready
  );
  modport slave (
    input  valid, op, key, value,
    output ready
  );
endinterface

interface ht_res_if #(
  parameter int KEY_WIDTH    = 32,
  parameter int VALUE_WIDTH  = 16,
  parameter int BUCKET_WIDTH = 8
);
  import hash_table_pkg::*;

  logic                    valid;
  logic                    ready;
  ht_op_e                  op;
  logic [KEY_WIDTH-1:0]    key;
  logic [VALUE_WIDTH-1:0]  value;
  ht_rescode_e             rescode;
  logic [VALUE_WIDTH-1:0]  found_value;
  logic [BUCKET_WIDTH-1:0] bucket;

  modport master (
    output valid, op, key, value,
    output rescode, found_value, bucket,
    input  ready
  );
  modport slave (
    input  valid, op, key, value,
    input  rescode, found_value, bucket,
    output ready
  );
endinterface

// File: rtl/hash_table_top.sv
// Chained hash table: per-bucket head pointers, linked entry store,
// one command in flight walking a chain one entry per cycle.
module hash_table_top #(
  parameter int KEY_WIDTH        = 32,
  parameter int VALUE_WIDTH      = 16,
  parameter int BUCKET_WIDTH     = 8,
  parameter int TABLE_ADDR_WIDTH = 8
) (
  input  logic     clk_i,
  input  logic     rst_i,
  ht_cmd_if.slave  ht_cmd_in,
  ht_res_if.master ht_res_out
);
  import hash_table_pkg::*;

  localparam int NB = 2 ** BUCKET_WIDTH;
  localparam int NE = 2 ** TABLE_ADDR_WIDTH;

  typedef logic [KEY_WIDTH-1:0]        key_t;
  typedef logic [VALUE_WIDTH-1:0]      val_t;
  typedef logic [BUCKET_WIDTH-1:0]     bkt_t;
  typedef logic [TABLE_ADDR_WIDTH-1:0] ptr_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_HEAD,
    S_WALK,
    S_UPDATE,
    S_RESULT
  } state_e;

  state_e      state_q, state_d;
  logic        ready_q, ready_d;
  ht_op_e      op_q, op_d;
  key_t        key_q, key_d;
  val_t        val_q, val_d;
  bkt_t        bkt_q, bkt_d;
  ptr_t        ptr_q, ptr_d;
  ptr_t        prev_q, prev_d;
  logic        first_q, first_d;
  logic        found_q, found_d;
  logic        chained_q, chained_d;

  logic        res_valid_q, res_valid_d;
  ht_op_e      res_op_q, res_op_d;
  key_t        res_key_q, res_key_d;
  val_t        res_val_q, res_val_d;
  ht_rescode_e rc_q, rc_d;
  val_t        fval_q, fval_d;
  bkt_t        res_bkt_q, res_bkt_d;

  logic [NB-1:0] head_valid_q, head_valid_d;
  logic [NE-1:0] free_q, free_d;

  ptr_t          head_ptr_q [NB];
  key_t          ent_key_q  [NE];
  val_t          ent_val_q  [NE];
  ptr_t          ent_next_q [NE];
  logic [NE-1:0] ent_nv_q;

  logic hp_we;
  bkt_t hp_addr;
  ptr_t hp_data;
  logic kv_we;
  ptr_t kv_addr;
  logic lka_we;
  ptr_t lka_addr;
  ptr_t lka_next;
  logic lka_nv;
  logic lkb_we;
  ptr_t lkb_addr;
  ptr_t lkb_next;

  logic alloc_ok;
  ptr_t alloc_ptr;

  key_t cur_key;
  val_t cur_val;
  ptr_t cur_next;
  logic cur_nv;

  assign cur_key  = ent_key_q[ptr_q];
  assign cur_val  = ent_val_q[ptr_q];
  assign cur_next = ent_next_q[ptr_q];
  assign cur_nv   = ent_nv_q[ptr_q];

  // Lowest free index wins.
  always_comb begin
    alloc_ok  = |free_q;
    alloc_ptr = '0;
    for (int i = NE - 1; i >= 0; i--) begin
      if (free_q[i]) alloc_ptr = ptr_t'(i);
    end
  end

  always_comb begin
    state_d      = state_q;
    ready_d      = ready_q;
    op_d         = op_q;
    key_d        = key_q;
    val_d        = val_q;
    bkt_d        = bkt_q;
    ptr_d        = ptr_q;
    prev_d       = prev_q;
    first_d      = first_q;
    found_d      = found_q;
    chained_d    = chained_q;
    res_valid_d  = res_valid_q;
    res_op_d     = res_op_q;
    res_key_d    = res_key_q;
    res_val_d    = res_val_q;
    rc_d         = rc_q;
    fval_d       = fval_q;
    res_bkt_d    = res_bkt_q;
    head_valid_d = head_valid_q;
    free_d       = free_q;
    hp_we        = 1'b0;
    hp_addr      = bkt_q;
    hp_data      = '0;
    kv_we        = 1'b0;
    kv_addr      = ptr_q;
    lka_we       = 1'b0;
    lka_addr     = ptr_q;
    lka_next     = '0;
    lka_nv       = 1'b0;
    lkb_we       = 1'b0;
    lkb_addr     = ptr_q;
    lkb_next     = alloc_ptr;

    unique case (state_q)
      S_IDLE: begin
        ready_d = 1'b1;
        if (ht_cmd_in.valid && ready_q) begin
          op_d    = ht_cmd_in.op;
          key_d   = ht_cmd_in.key;
          val_d   = ht_cmd_in.value;
          bkt_d   = ht_cmd_in.key[BUCKET_WIDTH-1:0];
          ready_d = 1'b0;
          state_d = S_HEAD;
        end
      end
      S_HEAD: begin
        ptr_d     = head_ptr_q[bkt_q];
        prev_d    = '0;
        first_d   = 1'b1;
        found_d   = 1'b0;
        chained_d = head_valid_q[bkt_q];
        state_d   = head_valid_q[bkt_q] ? S_WALK : S_UPDATE;
      end
      S_WALK: begin
        if (cur_key == key_q) begin
          found_d = 1'b1;
          state_d = S_UPDATE;
        end else if (cur_nv) begin
          prev_d  = ptr_q;
          ptr_d   = cur_next;
          first_d = 1'b0;
        end else begin
          state_d = S_UPDATE;
        end
      end
      S_UPDATE: begin
        state_d     = S_RESULT;
        res_valid_d = 1'b1;
        res_op_d    = op_q;
        res_key_d   = key_q;
        res_val_d   = val_q;
        res_bkt_d   = bkt_q;
        fval_d      = '0;
        // ptr_q is the match when found_q, else the chain tail.
        unique case (op_q)
          OP_INSERT: begin
            if (found_q) begin
              kv_we = 1'b1;
              rc_d  = INSERT_SUCCESS_SAME_KEY;
            end else if (alloc_ok) begin
              kv_we             = 1'b1;
              kv_addr           = alloc_ptr;
              lka_we            = 1'b1;
              lka_addr          = alloc_ptr;
              free_d[alloc_ptr] = 1'b0;
              if (chained_q) begin
                lkb_we = 1'b1;
              end else begin
                hp_we               = 1'b1;
                hp_data             = alloc_ptr;
                head_valid_d[bkt_q] = 1'b1;
              end
              rc_d = INSERT_SUCCESS;
            end else begin
              rc_d = INSERT_NOT_SUCCESS_TABLE_IS_FULL;
            end
          end
          OP_DELETE: begin
            if (found_q) begin
              free_d[ptr_q] = 1'b1;
              if (first_q) begin
                hp_we               = 1'b1;
                hp_data             = cur_next;
                head_valid_d[bkt_q] = cur_nv;
              end else begin
                lka_we   = 1'b1;
                lka_addr = prev_q;
                lka_next = cur_next;
                lka_nv   = cur_nv;
              end
              rc_d = DELETE_SUCCESS;
            end else begin
              rc_d = DELETE_NOT_SUCCESS_NO_ENTRY;
            end
          end
          default: begin
            if (found_q && op_q == OP_SEARCH) begin
              rc_d   = SEARCH_FOUND;
              fval_d = cur_val;
            end else begin
              rc_d = SEARCH_NOT_SUCCESS_NO_ENTRY;
            end
          end
        endcase
      end
      S_RESULT: begin
        if (ht_res_out.ready) begin
          res_valid_d = 1'b0;
          ready_d     = 1'b1;
          state_d     = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q      <= S_IDLE;
      ready_q      <= 1'b0;
      op_q         <= OP_SEARCH;
      key_q        <= '0;
      val_q        <= '0;
      bkt_q        <= '0;
      ptr_q        <= '0;
      prev_q       <= '0;
      first_q      <= 1'b0;
      found_q      <= 1'b0;
      chained_q    <= 1'b0;
      res_valid_q  <= 1'b0;
      res_op_q     <= OP_SEARCH;
      res_key_q    <= '0;
      res_val_q    <= '0;
      rc_q         <= SEARCH_FOUND;
      fval_q       <= '0;
      res_bkt_q    <= '0;
      head_valid_q <= '0;
      free_q       <= '1;
    end else begin
      state_q      <= state_d;
      ready_q      <= ready_d;
      op_q         <= op_d;
      key_q        <= key_d;
      val_q        <= val_d;
      bkt_q        <= bkt_d;
      ptr_q        <= ptr_d;
      prev_q       <= prev_d;
      first_q      <= first_d;
      found_q      <= found_d;
      chained_q    <= chained_d;
      res_valid_q  <= res_valid_d;
      res_op_q     <= res_op_d;
      res_key_q    <= res_key_d;
      res_val_q    <= res_val_d;
      rc_q         <= rc_d;
      fval_q       <= fval_d;
      res_bkt_q    <= res_bkt_d;
      head_valid_q <= head_valid_d;
      free_q       <= free_d;
    end
  end

  // Storage is guarded by head_valid/free bits, so it needs no reset.
  always_ff @(posedge clk_i) begin
    if (hp_we) head_ptr_q[hp_addr] <= hp_data;
    if (kv_we) begin
      ent_key_q[kv_addr] <= key_q;
      ent_val_q[kv_addr] <= val_q;
    end
    if (lka_we) begin
      ent_next_q[lka_addr] <= lka_next;
      ent_nv_q[lka_addr]   <= lka_nv;
    end
    if (lkb_we) begin
      ent_next_q[lkb_addr] <= lkb_next;
      ent_nv_q[lkb_addr]   <= 1'b1;
    end
  end

  assign ht_cmd_in.ready        = ready_q;
  assign ht_res_out.valid       = res_valid_q;
  assign ht_res_out.op          = res_op_q;
  assign ht_res_out.key         = res_key_q;
  assign ht_res_out.value       = res_val_q;
  assign ht_res_out.rescode     = rc_q;
  assign ht_res_out.found_value = fval_q;
  assign ht_res_out.bucket      = res_bkt_q;
endmodule

// File: tb/tb_hash_table_top.sv
// Randomized and directed bench for hash_table_top against a
// key-list reference model.
module tb_hash_table_top;
  import hash_table_pkg::*;

  typedef struct packed {
    logic        to;
    ht_rescode_e rc;
    logic [15:0] fv;
    logic [7:0]  bkt;
    logic [9:0]  lat;
    ht_op_e      op;
    logic [31:0] key;
    logic [15:0] val;
  } obs_t;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  logic [31:0] live_q [$];
  logic [15:0] mval [logic [31:0]];

  ht_cmd_if #(.KEY_WIDTH(32), .VALUE_WIDTH(16)) cmd_if ();
  ht_res_if #(.KEY_WIDTH(32), .VALUE_WIDTH(16), .BUCKET_WIDTH(8)) res_if ();

  hash_table_top #(
    .KEY_WIDTH(32),
    .VALUE_WIDTH(16),
    .BUCKET_WIDTH(8),
    .TABLE_ADDR_WIDTH(8)
  ) dut (
    .clk_i     (clk),
    .rst_i     (rst_n),
    .ht_cmd_in (cmd_if),
    .ht_res_out(res_if)
  );

  always #5 clk = ~clk;

  function automatic string show(obs_t o);
    return $sformatf("to=%0b rc=%0d fv=%h bkt=%h lat=%0d op=%0d key=%h val=%h",
                     o.to, o.rc, o.fv, o.bkt, o.lat, o.op, o.key, o.val);
  endfunction

  // Chain order in a bucket equals insertion order of live keys.
  function automatic obs_t model_exec(ht_op_e op, logic [31:0] key,
                                      logic [15:0] val);
    obs_t e;
    int   pos;
    int   idx;
    int   n;
    e = '0;
    e.op = op;
    e.key = key;
    e.val = val;
    e.bkt = key[7:0];
    pos = 0;
    idx = -1;
    n = 0;
    for (int i = 0; i < live_q.size(); i++) begin
      if (live_q[i][7:0] == key[7:0] && idx < 0) begin
        pos++;
        if (live_q[i] == key) idx = i;
      end
    end
    n = pos;
    case (op)
      OP_SEARCH: begin
        e.rc = (idx >= 0) ? SEARCH_FOUND : SEARCH_NOT_SUCCESS_NO_ENTRY;
        if (idx >= 0) e.fv = mval[key];
      end
      OP_INSERT: begin
        if (idx >= 0) begin
          mval[key] = val;
          e.rc = INSERT_SUCCESS_SAME_KEY;
        end else if (live_q.size() < 256) begin
          live_q.push_back(key);
          mval[key] = val;
          e.rc = INSERT_SUCCESS;
        end else begin
          e.rc = INSERT_NOT_SUCCESS_TABLE_IS_FULL;
        end
      end
      default: begin
        if (idx >= 0) begin
          live_q.delete(idx);
          mval.delete(key);
          e.rc = DELETE_SUCCESS;
        end else begin
          e.rc = DELETE_NOT_SUCCESS_NO_ENTRY;
        end
      end
    endcase
    e.lat = 10'(3 + n);
    return e;
  endfunction

  task automatic model_clear();
    live_q.delete();
    mval.delete();
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0;
    cmd_if.valid = 1'b0;
    res_if.ready = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    model_clear();
    @(posedge clk);
    #1;
  endtask

  task automatic send_and_wait(input ht_op_e op, input logic [31:0] key,
                               input logic [15:0] val, output obs_t o);
    int w;
    o = '0;
    @(negedge clk);
    cmd_if.valid = 1'b1;
    cmd_if.op    = op;
    cmd_if.key   = key;
    cmd_if.value = val;
    w = 0;
    while (cmd_if.ready !== 1'b1 && w < 64) begin
      @(negedge clk);
      w++;
    end
    if (cmd_if.ready !== 1'b1) begin
      cmd_if.valid = 1'b0;
      o.to = 1'b1;
      return;
    end
    @(posedge clk);
    #1;
    cmd_if.valid = 1'b0;
    o.lat = 10'd1;
    @(negedge clk);
    while (res_if.valid !== 1'b1 && o.lat < 10'd1000) begin
      @(posedge clk);
      o.lat++;
      @(negedge clk);
    end
    if (res_if.valid !== 1'b1) begin
      o.to = 1'b1;
      return;
    end
    o.rc  = res_if.rescode;
    o.fv  = (op == OP_SEARCH) ? res_if.found_value : 16'h0;
    o.bkt = res_if.bucket;
    o.op  = res_if.op;
    o.key = res_if.key;
    o.val = res_if.value;
  endtask

  task automatic pop_result(input int hold);
    repeat (hold) @(negedge clk);
    res_if.ready = 1'b1;
    @(posedge clk);
    #1;
    res_if.ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (cmd_if.ready !== 1'b0 || res_if.valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_hs act cmd_ready=%b res_valid=%b req 0 0",
               cmd_if.ready, res_if.valid);
    end
    checks++;
    if ({res_if.rescode, res_if.found_value, res_if.bucket,
         res_if.op, res_if.key, res_if.value} !== '0) begin
      failures++;
      $display("FAIL reset_fields act rc=%0d fv=%h bkt=%h key=%h req all 0",
               res_if.rescode, res_if.found_value, res_if.bucket, res_if.key);
    end
    rst_n = 1'b1;
    model_clear();
    @(posedge clk);
    #1;
    checks++;
    if (cmd_if.ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_ready_first_edge act %b req 1", cmd_if.ready);
    end
  endtask

  task automatic test_same_key();
    ht_op_e      ops  [4] = '{OP_INSERT, OP_INSERT, OP_INSERT, OP_SEARCH};
    logic [31:0] keys [4] = '{32'h01000000, 32'h01001000,
                              32'h01000000, 32'h01000000};
    logic [15:0] vals [4] = '{16'h1234, 16'h1235, 16'h5678, 16'h0000};
    obs_t o, e;
    for (int i = 0; i < 4; i++) begin
      send_and_wait(ops[i], keys[i], vals[i], o);
      e = model_exec(ops[i], keys[i], vals[i]);
      checks++;
      if (o !== e) begin
        failures++;
        $display("FAIL same_key[%0d] act %s req %s", i, show(o), show(e));
      end
      pop_result(0);
    end
  endtask

  task automatic test_chain();
    ht_op_e      op;
    logic [31:0] k;
    obs_t o, e;
    apply_reset();
    for (int i = 0; i < 13; i++) begin
      if (i < 4) begin
        op = OP_INSERT;
        k = {8'(i), 24'h0};
      end else if (i < 8) begin
        op = OP_SEARCH;
        k = {8'(7 - i), 24'h0};
      end else if (i < 12) begin
        op = OP_DELETE;
        k = {8'(i - 8), 24'h0};
      end else begin
        op = OP_SEARCH;
        k = 32'h0;
      end
      send_and_wait(op, k, 16'hA000 + 16'(i), o);
      e = model_exec(op, k, 16'hA000 + 16'(i));
      checks++;
      if (o !== e) begin
        failures++;
        $display("FAIL chain[%0d] act %s req %s", i, show(o), show(e));
      end
      pop_result(0);
    end
  endtask

  task automatic test_empty_and_miss();
    ht_op_e      ops  [6] = '{OP_SEARCH, OP_DELETE, OP_INSERT,
                              OP_SEARCH, OP_DELETE, OP_SEARCH};
    logic [31:0] keys [6] = '{32'h04000000, 32'h04111111, 32'h04000000,
                              32'h04100000, 32'h04100000, 32'h04000000};
    obs_t o, e;
    apply_reset();
    for (int i = 0; i < 6; i++) begin
      send_and_wait(ops[i], keys[i], 16'h4400 + 16'(i), o);
      e = model_exec(ops[i], keys[i], 16'h4400 + 16'(i));
      checks++;
      if (o !== e) begin
        failures++;
        $display("FAIL miss[%0d] act %s req %s", i, show(o), show(e));
      end
      pop_result(0);
    end
  endtask

  task automatic test_reuse_and_full();
    ht_op_e      ops  [11] = '{OP_INSERT, OP_INSERT, OP_DELETE, OP_INSERT,
                               OP_INSERT, OP_INSERT, OP_INSERT, OP_SEARCH,
                               OP_DELETE, OP_INSERT, OP_SEARCH};
    logic [31:0] keys [11] = '{32'h05000000, 32'h05000001, 32'h05000001,
                               32'h05000002, 32'h05000003, 32'hAC0000FF,
                               32'hAB000005, 32'hAC0000FF, 32'hAB000007,
                               32'hAC0000FF, 32'hAC0000FF};
    obs_t o, e;
    apply_reset();
    for (int i = 0; i < 11; i++) begin
      if (i == 5) begin
        for (int j = 0; j < 253; j++) begin
          send_and_wait(OP_INSERT, 32'hAB000000 | 32'(j), 16'(j), o);
          e = model_exec(OP_INSERT, 32'hAB000000 | 32'(j), 16'(j));
          checks++;
          if (o !== e) begin
            failures++;
            $display("FAIL fill[%0d] act %s req %s", j, show(o), show(e));
          end
          pop_result(0);
        end
      end
      send_and_wait(ops[i], keys[i], 16'h5500 + 16'(i), o);
      e = model_exec(ops[i], keys[i], 16'h5500 + 16'(i));
      checks++;
      if (o !== e) begin
        failures++;
        $display("FAIL reuse_full[%0d] act %s req %s", i, show(o), show(e));
      end
      pop_result(0);
    end
  endtask

  task automatic test_backpressure();
    obs_t o, e;
    send_and_wait(OP_INSERT, 32'h06000006, 16'hBEEF, o);
    e = model_exec(OP_INSERT, 32'h06000006, 16'hBEEF);
    checks++;
    if (o !== e) begin
      failures++;
      $display("FAIL bp_first act %s req %s", show(o), show(e));
    end
    cmd_if.valid = 1'b1;
    cmd_if.op    = OP_SEARCH;
    cmd_if.key   = 32'h06000006;
    cmd_if.value = 16'h0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      checks++;
      if (res_if.valid !== 1'b1 || cmd_if.ready !== 1'b0 ||
          res_if.rescode !== e.rc || res_if.bucket !== e.bkt ||
          res_if.key !== e.key || res_if.value !== e.val) begin
        failures++;
        $display("FAIL bp_hold[%0d] act v=%b rdy=%b rc=%0d key=%h req v=1 rdy=0 rc=%0d key=%h",
                 c, res_if.valid, cmd_if.ready, res_if.rescode, res_if.key,
                 e.rc, e.key);
      end
    end
    pop_result(0);
    send_and_wait(OP_SEARCH, 32'h06000006, 16'h0, o);
    e = model_exec(OP_SEARCH, 32'h06000006, 16'h0);
    checks++;
    if (o !== e) begin
      failures++;
      $display("FAIL bp_next act %s req %s", show(o), show(e));
    end
    pop_result(0);
  endtask

  task automatic test_random();
    ht_op_e      op;
    logic [31:0] k;
    logic [15:0] v;
    obs_t o, e;
    apply_reset();
    for (int i = 0; i < 300; i++) begin
      op = ht_op_e'($urandom_range(0, 2));
      k  = {8'($urandom_range(0, 5)), 16'h0, 8'($urandom_range(0, 3))};
      v  = 16'($urandom);
      send_and_wait(op, k, v, o);
      e = model_exec(op, k, v);
      checks++;
      if (o !== e) begin
        failures++;
        $display("FAIL random[%0d] act %s req %s", i, show(o), show(e));
      end
      pop_result($urandom_range(0, 2));
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] keys [3] = '{32'h10000077, 32'h20000077, 32'h30000077};
    obs_t o, e;
    int   w;
    apply_reset();
    for (int i = 0; i < 3; i++) begin
      send_and_wait(OP_INSERT, keys[i], 16'h7700 + 16'(i), o);
      e = model_exec(OP_INSERT, keys[i], 16'h7700 + 16'(i));
      checks++;
      if (o !== e) begin
        failures++;
        $display("FAIL rmid_fill[%0d] act %s req %s", i, show(o), show(e));
      end
      pop_result(0);
    end
    @(negedge clk);
    cmd_if.valid = 1'b1;
    cmd_if.op    = OP_SEARCH;
    cmd_if.key   = 32'h30000077;
    w = 0;
    while (cmd_if.ready !== 1'b1 && w < 64) begin
      @(negedge clk);
      w++;
    end
    @(posedge clk);
    #1;
    cmd_if.valid = 1'b0;
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    model_clear();
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++;
      if (res_if.valid !== 1'b0 || cmd_if.ready !== 1'b0) begin
        failures++;
        $display("FAIL rmid_in_reset[%0d] act v=%b rdy=%b req 0 0",
                 c, res_if.valid, cmd_if.ready);
      end
    end
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (res_if.valid !== 1'b0 || cmd_if.ready !== 1'b1) begin
      failures++;
      $display("FAIL rmid_after act v=%b rdy=%b req 0 1",
               res_if.valid, cmd_if.ready);
    end
    for (int i = 0; i < 3; i++) begin
      send_and_wait(OP_SEARCH, keys[i], 16'h0, o);
      e = model_exec(OP_SEARCH, keys[i], 16'h0);
      checks++;
      if (o !== e) begin
        failures++;
        $display("FAIL rmid_empty[%0d] act %s req %s", i, show(o), show(e));
      end
      pop_result(0);
    end
  endtask

  initial begin
    clk          = 1'b0;
    rst_n        = 1'b0;
    checks       = 0;
    failures     = 0;
    cmd_if.valid = 1'b0;
    cmd_if.op    = OP_SEARCH;
    cmd_if.key   = '0;
    cmd_if.value = '0;
    res_if.ready = 1'b0;
    test_reset();
    test_same_key();
    test_chain();
    test_empty_and_miss();
    test_reuse_and_full();
    test_backpressure();
    test_random();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
